cpu_dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 16-bit Wishbone data-memory bus. Port 0 carries execute-stage stores, including both halves of split 32-bit `.l` stores. Port 1 carries memory-stage loads. The block serialises both ports onto one classic Wishbone master, holds the bus across two-beat 32-bit accesses, raises a pipeline stall while a requester waits, and aborts hung cycles with a watchdog.

---
 rtl/cpu_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_cpu_dmem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_dmem_arbiter
// Two-port arbiter/sequencer for the shared 16-bit Wishbone data-memory bus.
//   Port 0: execute-stage stores (including both halves of split .l stores).
//   Port 1: memory-stage loads (wins ties; it holds the older instruction).
// A locked beat keeps the bus in HOLD so the second half of a 32-bit access
// cannot be interleaved with the other port. A watchdog aborts slaves that
// never acknowledge.
// ---------------------------------------------------------------------------
module cpu_dmem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,

  // Port 0: execute-stage stores
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  input  logic        m0_lock_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [15:0] m0_dat_o,

  // Port 1: memory-stage loads
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic        m1_lock_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [15:0] m1_dat_o,

  // Shared Wishbone master
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,

  // Pipeline stall
  output logic        stall_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // Last watchdog count value tolerated without an ack.
  localparam logic [7:0] LP_WDOG_LAST = 8'(TIMEOUT - 1);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t      r_state;
  logic        r_owner;
  logic        r_granted;
  logic [7:0]  r_wdog;

  logic        r_wb_cyc;
  logic        r_wb_stb;
  logic        r_wb_we;
  logic [1:0]  r_wb_sel;
  logic [31:0] r_wb_adr;
  logic [15:0] r_wb_dat;

  logic        r_m0_err;
  logic        r_m1_err;

  // -------------------------------------------------------------------------
  // Request decode and port selection
  // -------------------------------------------------------------------------
  logic        w_req0;
  logic        w_req1;
  logic        w_busy;
  logic        w_pick;        // port whose request fields are looked at
  logic        w_pick_cyc;
  logic        w_pick_stb;
  logic        w_pick_we;
  logic [1:0]  w_pick_sel;
  logic [31:0] w_pick_adr;
  logic [15:0] w_pick_dat;
  logic        w_pick_lock;
  logic        w_any_req;
  logic        w_wdog_expired;

  assign w_req0         = m0_cyc_i & m0_stb_i;
  assign w_req1         = m1_cyc_i & m1_stb_i;
  assign w_any_req      = w_req0 | w_req1;
  assign w_busy         = (r_state == ST_BUSY);
  assign w_wdog_expired = (r_wdog == LP_WDOG_LAST);

  // In IDLE the arbitration winner is selected (port 1 on a tie);
  // otherwise the current owner's request fields are selected.
  always_comb begin
    w_pick = r_owner;
    if (r_state == ST_IDLE) begin
      w_pick = w_req1;
    end else begin
      w_pick = r_owner;
    end
  end

  // Mux the selected port's request fields.
  always_comb begin
    w_pick_cyc  = 1'b0;
    w_pick_stb  = 1'b0;
    w_pick_we   = 1'b0;
    w_pick_sel  = 2'b00;
    w_pick_adr  = 32'h0000_0000;
    w_pick_dat  = 16'h0000;
    w_pick_lock = 1'b0;
    if (w_pick) begin
      w_pick_cyc  = m1_cyc_i;
      w_pick_stb  = m1_stb_i;
      w_pick_we   = m1_we_i;
      w_pick_sel  = m1_sel_i;
      w_pick_adr  = m1_adr_i;
      w_pick_dat  = m1_dat_i;
      w_pick_lock = m1_lock_i;
    end else begin
      w_pick_cyc  = m0_cyc_i;
      w_pick_stb  = m0_stb_i;
      w_pick_we   = m0_we_i;
      w_pick_sel  = m0_sel_i;
      w_pick_adr  = m0_adr_i;
      w_pick_dat  = m0_dat_i;
      w_pick_lock = m0_lock_i;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer: arbitration, beat latching, lock hold, watchdog abort
  // -------------------------------------------------------------------------
  // Single FSM block owning all state and every registered bus output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_granted <= 1'b0;
      r_wdog    <= 8'd0;
      r_wb_cyc  <= 1'b0;
      r_wb_stb  <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_sel  <= 2'b00;
      r_wb_adr  <= 32'h0000_0000;
      r_wb_dat  <= 16'h0000;
      r_m0_err  <= 1'b0;
      r_m1_err  <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses.
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_req1;
            r_granted <= 1'b1;
            r_wdog    <= 8'd0;
            r_wb_cyc  <= 1'b1;
            r_wb_stb  <= 1'b1;
            r_wb_we   <= w_pick_we;
            r_wb_sel  <= w_pick_sel;
            r_wb_adr  <= w_pick_adr;
            r_wb_dat  <= w_pick_dat;
            r_state   <= ST_BUSY;
          end else begin
            r_granted <= 1'b0;
            r_wb_cyc  <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        ST_BUSY: begin
          if (wb_ack_i) begin
            // Ack beats the watchdog when both land in the same cycle.
            if (w_pick_lock) begin
              r_wb_stb <= 1'b0;
              r_state  <= ST_HOLD;
            end else begin
              r_wb_cyc  <= 1'b0;
              r_wb_stb  <= 1'b0;
              r_granted <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end else if (w_wdog_expired) begin
            if (r_owner) begin
              r_m1_err <= 1'b1;
            end else begin
              r_m0_err <= 1'b1;
            end
            r_wb_cyc  <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_granted <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_wdog  <= r_wdog + 8'd1;
            r_state <= ST_BUSY;
          end
        end

        ST_HOLD: begin
          if (w_pick_cyc && w_pick_stb) begin
            // Second half of a locked access: new beat, same owner.
            r_wdog   <= 8'd0;
            r_wb_stb <= 1'b1;
            r_wb_we  <= w_pick_we;
            r_wb_sel <= w_pick_sel;
            r_wb_adr <= w_pick_adr;
            r_wb_dat <= w_pick_dat;
            r_state  <= ST_BUSY;
          end else if (!w_pick_cyc) begin
            r_wb_cyc  <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_granted <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end

        default: begin
          r_wb_cyc  <= 1'b0;
          r_wb_stb  <= 1'b0;
          r_granted <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wb_cyc_o = r_wb_cyc;
  assign wb_stb_o = r_wb_stb;
  assign wb_we_o  = r_wb_we;
  assign wb_sel_o = r_wb_sel;
  assign wb_adr_o = r_wb_adr;
  assign wb_dat_o = r_wb_dat;
  assign m0_err_o = r_m0_err;
  assign m1_err_o = r_m1_err;

  // Read data is shared; each consumer qualifies it with its own ack.
  assign m0_dat_o = wb_dat_i;
  assign m1_dat_o = wb_dat_i;

  // Acks pass through combinationally, only to the granted owner in BUSY.
  assign m0_ack_o = wb_ack_i & r_granted & ~r_owner & w_busy;
  assign m1_ack_o = wb_ack_i & r_granted &  r_owner & w_busy;

  // Stall while any requester has a beat that is not completing this cycle.
  assign stall_o = (w_req0 & ~(w_busy & ~r_owner & wb_ack_i)) |
                   (w_req1 & ~(w_busy &  r_owner & wb_ack_i));

endmodule

// File: tb/tb_cpu_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for cpu_dmem_arbiter. Expected bus beats are queued when a
// request is driven and compared when the bus completes a beat.
// ---------------------------------------------------------------------------
module tb_cpu_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_lock_i;
  logic [1:0]  m0_sel_i;
  logic [31:0] m0_adr_i;
  logic [15:0] m0_dat_i;
  logic        m0_ack_o, m0_err_o;
  logic [15:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_lock_i;
  logic [1:0]  m1_sel_i;
  logic [31:0] m1_adr_i;
  logic [15:0] m1_dat_i;
  logic        m1_ack_o, m1_err_o;
  logic [15:0] m1_dat_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [1:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;
  logic        stall_o;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] adr;
    logic [15:0] dat;
  } txn_t;

  txn_t sb_q[$];
  txn_t mon_t;
  int   n_tests = 0;
  int   n_fail  = 0;

  cpu_dmem_arbiter #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_lock_i(m0_lock_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_lock_i(m1_lock_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic push(input logic p, input logic we, input logic [1:0] sel,
                      input logic [31:0] adr, input logic [15:0] dat);
    txn_t t;
    t.port = p; t.we = we; t.sel = sel; t.adr = adr; t.dat = dat;
    sb_q.push_back(t);
  endtask

  task automatic req0(input logic we, input logic [1:0] sel, input logic [31:0] adr,
                      input logic [15:0] dat, input logic lock);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we; m0_sel_i = sel;
    m0_adr_i = adr; m0_dat_i = dat; m0_lock_i = lock;
  endtask

  task automatic req1(input logic we, input logic [1:0] sel, input logic [31:0] adr,
                      input logic [15:0] dat, input logic lock);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = we; m1_sel_i = sel;
    m1_adr_i = adr; m1_dat_i = dat; m1_lock_i = lock;
  endtask

  task automatic drop0();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_lock_i = 1'b0;
  endtask

  task automatic drop1();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_lock_i = 1'b0;
  endtask

  // Scoreboard: every completed bus beat must match the oldest queued request.
  always @(negedge clk_i) begin
    if (!rst_i && wb_cyc_o && wb_stb_o && wb_ack_i) begin
      n_tests++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected_beat: observed adr %0h expected no beat", wb_adr_o);
      end
      if (sb_q.size() != 0) begin
        mon_t = sb_q.pop_front();
        chkw("sb_beat", {13'd0, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o},
             {13'd0, mon_t.we, mon_t.sel, mon_t.adr, mon_t.dat});
        chkw("sb_ack_port", {62'd0, m1_ack_o, m0_ack_o},
             mon_t.port ? 64'd2 : 64'd1);
      end
    end
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1;
    drop0(); drop1();
    m0_we_i = 1'b0; m0_sel_i = 2'b00; m0_adr_i = 32'd0; m0_dat_i = 16'd0;
    m1_we_i = 1'b0; m1_sel_i = 2'b00; m1_adr_i = 32'd0; m1_dat_i = 16'd0;
    wb_ack_i = 1'b1;          // ack during reset must not reach any port
    wb_dat_i = 16'd0;

    // ---- reset values ----
    #2;
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk1("rst_stb", wb_stb_o, 1'b0);
    chk1("rst_we",  wb_we_o,  1'b0);
    chkw("rst_sel", 64'(wb_sel_o), 64'd0);
    chkw("rst_adr", 64'(wb_adr_o), 64'd0);
    chkw("rst_dat", 64'(wb_dat_o), 64'd0);
    chk1("rst_err0", m0_err_o, 1'b0);
    chk1("rst_err1", m1_err_o, 1'b0);
    chk1("rst_ack0", m0_ack_o, 1'b0);
    chk1("rst_ack1", m1_ack_o, 1'b0);
    step();
    rst_i = 1'b0; wb_ack_i = 1'b0;
    sample();
    chk1("idle_stall", stall_o, 1'b0);
    chk1("idle_cyc", wb_cyc_o, 1'b0);

    // ---- single store, zero-wait slave ----
    step();
    req0(1'b1, 2'b11, 32'h0000_1000, 16'hBEEF, 1'b0);
    push(1'b0, 1'b1, 2'b11, 32'h0000_1000, 16'hBEEF);
    sample();
    chk1("st_stall_req", stall_o, 1'b1);
    chk1("st_cyc_req", wb_cyc_o, 1'b0);
    step();
    wb_ack_i = 1'b1;
    sample();
    chk1("st_cyc", wb_cyc_o, 1'b1);
    chk1("st_stb", wb_stb_o, 1'b1);
    chk1("st_ack0", m0_ack_o, 1'b1);
    chk1("st_ack1", m1_ack_o, 1'b0);
    chk1("st_stall_ack", stall_o, 1'b0);
    step();
    drop0(); wb_ack_i = 1'b0;
    sample();
    chk1("st_release_cyc", wb_cyc_o, 1'b0);
    chk1("st_release_stb", wb_stb_o, 1'b0);
    chk1("st_ack_once", m0_ack_o, 1'b0);

    // ---- contention: port 1 first ----
    step();
    req1(1'b0, 2'b11, 32'h0000_2000, 16'h0000, 1'b0);
    req0(1'b1, 2'b11, 32'h0000_1004, 16'hCAFE, 1'b0);
    push(1'b1, 1'b0, 2'b11, 32'h0000_2000, 16'h0000);
    push(1'b0, 1'b1, 2'b11, 32'h0000_1004, 16'hCAFE);
    sample();
    chk1("ct_stall_req", stall_o, 1'b1);
    step();
    wb_ack_i = 1'b1; wb_dat_i = 16'hA5A5;
    sample();
    chk1("ct_ack1", m1_ack_o, 1'b1);
    chkw("ct_rdata1", 64'(m1_dat_o), 64'h0000_0000_0000_A5A5);
    chk1("ct_ack0_blocked", m0_ack_o, 1'b0);
    chk1("ct_stall_wait", stall_o, 1'b1);
    step();
    drop1(); wb_ack_i = 1'b0;
    sample();
    chk1("ct_gap_cyc", wb_cyc_o, 1'b0);
    chk1("ct_gap_stall", stall_o, 1'b1);
    step();
    wb_ack_i = 1'b1;
    sample();
    chk1("ct_ack0", m0_ack_o, 1'b1);
    chk1("ct_ack1_off", m1_ack_o, 1'b0);
    chk1("ct_stall_done", stall_o, 1'b0);
    step();
    drop0(); wb_ack_i = 1'b0;
    sample();
    chk1("ct_release", wb_cyc_o, 1'b0);

    // ---- locked .l store with port 1 waiting ----
    step();
    req0(1'b1, 2'b11, 32'h0000_3000, 16'h1234, 1'b1);
    push(1'b0, 1'b1, 2'b11, 32'h0000_3000, 16'h1234);
    sample();
    chk1("lk_idle_cyc", wb_cyc_o, 1'b0);
    step();
    wb_ack_i = 1'b1;
    req1(1'b0, 2'b11, 32'h0000_2004, 16'h0000, 1'b0);
    sample();
    chk1("lk_ack0_a", m0_ack_o, 1'b1);
    chk1("lk_ack1_a", m1_ack_o, 1'b0);
    chk1("lk_stall_a", stall_o, 1'b1);
    step();
    wb_ack_i = 1'b0;
    req0(1'b1, 2'b11, 32'h0000_3002, 16'h5678, 1'b0);
    push(1'b0, 1'b1, 2'b11, 32'h0000_3002, 16'h5678);
    push(1'b1, 1'b0, 2'b11, 32'h0000_2004, 16'h0000);
    sample();
    chk1("lk_hold_cyc", wb_cyc_o, 1'b1);
    chk1("lk_hold_stb", wb_stb_o, 1'b0);
    chk1("lk_hold_ack1", m1_ack_o, 1'b0);
    chk1("lk_hold_stall", stall_o, 1'b1);
    step();
    wb_ack_i = 1'b1;
    sample();
    chk1("lk_cyc_b", wb_cyc_o, 1'b1);
    chk1("lk_ack0_b", m0_ack_o, 1'b1);
    chk1("lk_ack1_b", m1_ack_o, 1'b0);
    chk1("lk_stall_b", stall_o, 1'b1);
    step();
    drop0(); wb_ack_i = 1'b0;
    sample();
    chk1("lk_release", wb_cyc_o, 1'b0);
    chk1("lk_stall_p1", stall_o, 1'b1);
    step();
    wb_ack_i = 1'b1; wb_dat_i = 16'h0F0F;
    sample();
    chk1("lk_ack1_c", m1_ack_o, 1'b1);
    chkw("lk_rdata1", 64'(m1_dat_o), 64'h0000_0000_0000_0F0F);
    chk1("lk_stall_c", stall_o, 1'b0);
    step();
    drop1(); wb_ack_i = 1'b0;

    // ---- watchdog: no ack for 16 BUSY cycles ----
    step();
    req1(1'b0, 2'b11, 32'h0000_4000, 16'h0000, 1'b0);
    sample();
    chk1("wd_idle", wb_cyc_o, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step();
      sample();
      chk1("wd_cyc_held", wb_cyc_o, 1'b1);
      chk1("wd_no_err", m1_err_o, 1'b0);
    end
    step();
    drop1();
    req0(1'b1, 2'b01, 32'h0000_4002, 16'h0001, 1'b0);
    push(1'b0, 1'b1, 2'b01, 32'h0000_4002, 16'h0001);
    sample();
    chk1("wd_err1", m1_err_o, 1'b1);
    chk1("wd_err0", m0_err_o, 1'b0);
    chk1("wd_cyc_drop", wb_cyc_o, 1'b0);
    chk1("wd_stb_drop", wb_stb_o, 1'b0);
    step();
    wb_ack_i = 1'b1;
    sample();
    chk1("wd_err_pulse", m1_err_o, 1'b0);
    chk1("wd_regrant_stb", wb_stb_o, 1'b1);
    chk1("wd_regrant_ack", m0_ack_o, 1'b1);
    step();
    drop0(); wb_ack_i = 1'b0;
    sample();
    chk1("wd_release", wb_cyc_o, 1'b0);

    // ---- ack collides with watchdog expiry ----
    step();
    req1(1'b0, 2'b10, 32'h0000_5000, 16'h0000, 1'b0);
    push(1'b1, 1'b0, 2'b10, 32'h0000_5000, 16'h0000);
    sample();
    for (int i = 1; i <= 15; i++) begin
      step();
      sample();
      chk1("co_wait_ack", m1_ack_o, 1'b0);
    end
    step();
    wb_ack_i = 1'b1; wb_dat_i = 16'h1357;
    sample();
    chk1("co_ack", m1_ack_o, 1'b1);
    chkw("co_rdata", 64'(m1_dat_o), 64'h0000_0000_0000_1357);
    chk1("co_err_now", m1_err_o, 1'b0);
    step();
    drop1(); wb_ack_i = 1'b0;
    sample();
    chk1("co_err_after", m1_err_o, 1'b0);
    chk1("co_release", wb_cyc_o, 1'b0);

    // ---- reset while port 0 holds the bus ----
    step();
    req0(1'b1, 2'b11, 32'h0000_6000, 16'hABCD, 1'b1);
    push(1'b0, 1'b1, 2'b11, 32'h0000_6000, 16'hABCD);
    sample();
    step();
    wb_ack_i = 1'b1;
    sample();
    chk1("rh_ack0", m0_ack_o, 1'b1);
    step();
    wb_ack_i = 1'b0;
    m0_stb_i = 1'b0;
    req1(1'b0, 2'b11, 32'h0000_6100, 16'h0000, 1'b0);
    sample();
    chk1("rh_hold_cyc", wb_cyc_o, 1'b1);
    chk1("rh_hold_stb", wb_stb_o, 1'b0);
    #2;
    rst_i = 1'b1; wb_ack_i = 1'b1;
    #1;
    chk1("rh_cyc", wb_cyc_o, 1'b0);
    chk1("rh_stb", wb_stb_o, 1'b0);
    chk1("rh_we", wb_we_o, 1'b0);
    chkw("rh_sel", 64'(wb_sel_o), 64'd0);
    chkw("rh_adr", 64'(wb_adr_o), 64'd0);
    chkw("rh_dat", 64'(wb_dat_o), 64'd0);
    chk1("rh_ack0_off", m0_ack_o, 1'b0);
    chk1("rh_ack1_off", m1_ack_o, 1'b0);
    chk1("rh_err0", m0_err_o, 1'b0);
    chk1("rh_err1", m1_err_o, 1'b0);
    drop0();
    step();
    rst_i = 1'b0; wb_ack_i = 1'b0;
    push(1'b1, 1'b0, 2'b11, 32'h0000_6100, 16'h0000);
    sample();
    chk1("rh_post_idle", wb_cyc_o, 1'b0);
    chk1("rh_post_stall", stall_o, 1'b1);
    step();
    wb_ack_i = 1'b1;
    sample();
    chk1("rh_p1_cyc", wb_cyc_o, 1'b1);
    chk1("rh_p1_ack", m1_ack_o, 1'b1);
    chk1("rh_p0_ack", m0_ack_o, 1'b0);
    step();
    drop1(); wb_ack_i = 1'b0;
    sample();
    chk1("rh_final_release", wb_cyc_o, 1'b0);
    chkw("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
